// File: rtl/logic2048_board_ctrl.sv
// rtl/logic2048_board_ctrl.sv - 2048 board controller with line feed, write-back, spawn and game-over
module logic2048_board_ctrl #(
    parameter logic [15:0] LFSR_SEED      = 16'hACE1,
    parameter logic [2:0]  FOUR_PROB_MASK = 3'd3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_new,
    input  logic [1:0]  cmd_dir,
    output logic [3:0]  ln_x0,
    output logic [3:0]  ln_x1,
    output logic [3:0]  ln_x2,
    output logic [3:0]  ln_x3,
    input  logic [3:0]  ln_y0,
    input  logic [3:0]  ln_y1,
    input  logic [3:0]  ln_y2,
    input  logic [3:0]  ln_y3,
    input  logic        ln_movable,
    output logic [63:0] board,
    output logic        done,
    output logic        moved,
    output logic        game_over
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_SPAWN,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] board_q, board_d;
    logic [15:0] lfsr_q;
    logic [1:0]  line_q, line_d;
    logic [1:0]  dir_q, dir_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  scan_q, scan_d;
    logic        spawn2_q, spawn2_d;
    logic        acc_q, acc_d;
    logic        moved_q, moved_d;
    logic        over_q, over_d;

    logic        lfsr_fb;
    logic [3:0]  spawn_code;
    logic [3:0]  c0, c1, c2, c3;

    function automatic logic [3:0] cell_of(input logic [1:0] dir, input logic [1:0] line,
                                           input logic [1:0] k);
        case (dir)
            2'd0:    cell_of = {line, k};
            2'd1:    cell_of = {line, ~k};
            2'd2:    cell_of = {k, line};
            default: cell_of = {~k, line};
        endcase
    endfunction

    function automatic logic calc_over(input logic [63:0] b);
        logic over;
        over = 1'b1;
        for (int n = 0; n < 16; n++) begin
            if (b[n*4 +: 4] == 4'd0) over = 1'b0;
            if ((n % 4) != 3 && b[n*4 +: 4] == b[(n+1)*4 +: 4]) over = 1'b0;
            if (n < 12 && b[n*4 +: 4] == b[(n+4)*4 +: 4]) over = 1'b0;
        end
        calc_over = over;
    endfunction

    assign lfsr_fb    = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign spawn_code = ((lfsr_q[7:5] & FOUR_PROB_MASK) == 3'd0) ? 4'd2 : 4'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            board_q  <= '0;
            lfsr_q   <= LFSR_SEED;
            line_q   <= '0;
            dir_q    <= '0;
            idx_q    <= '0;
            scan_q   <= '0;
            spawn2_q <= 1'b0;
            acc_q    <= 1'b0;
            moved_q  <= 1'b0;
            over_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            board_q  <= board_d;
            lfsr_q   <= {lfsr_q[14:0], lfsr_fb};
            line_q   <= line_d;
            dir_q    <= dir_d;
            idx_q    <= idx_d;
            scan_q   <= scan_d;
            spawn2_q <= spawn2_d;
            acc_q    <= acc_d;
            moved_q  <= moved_d;
            over_q   <= over_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        board_d   = board_q;
        line_d    = line_q;
        dir_d     = dir_q;
        idx_d     = idx_q;
        scan_d    = scan_q;
        spawn2_d  = spawn2_q;
        acc_d     = acc_q;
        moved_d   = moved_q;
        over_d    = over_q;
        cmd_ready = 1'b0;
        ln_x0     = 4'd0;
        ln_x1     = 4'd0;
        ln_x2     = 4'd0;
        ln_x3     = 4'd0;
        c0        = cell_of(dir_q, line_q, 2'd0);
        c1        = cell_of(dir_q, line_q, 2'd1);
        c2        = cell_of(dir_q, line_q, 2'd2);
        c3        = cell_of(dir_q, line_q, 2'd3);

        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    acc_d = 1'b0;
                    if (cmd_new) begin
                        board_d  = '0;
                        moved_d  = 1'b0;
                        spawn2_d = 1'b1;
                        idx_d    = lfsr_q[3:0];
                        scan_d   = '0;
                        state_d  = S_SPAWN;
                    end else begin
                        dir_d   = cmd_dir;
                        line_d  = '0;
                        state_d = S_SHIFT;
                    end
                end
            end

            S_SHIFT: begin
                ln_x0 = board_q[{c0, 2'b00} +: 4];
                ln_x1 = board_q[{c1, 2'b00} +: 4];
                ln_x2 = board_q[{c2, 2'b00} +: 4];
                ln_x3 = board_q[{c3, 2'b00} +: 4];
                board_d[{c0, 2'b00} +: 4] = ln_y0;
                board_d[{c1, 2'b00} +: 4] = ln_y1;
                board_d[{c2, 2'b00} +: 4] = ln_y2;
                board_d[{c3, 2'b00} +: 4] = ln_y3;
                acc_d  = acc_q | ln_movable;
                line_d = line_q + 2'd1;
                if (line_q == 2'd3) begin
                    if (acc_d) begin
                        idx_d    = lfsr_q[3:0];
                        scan_d   = '0;
                        spawn2_d = 1'b0;
                        state_d  = S_SPAWN;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end

            S_SPAWN: begin
                if (board_q[{idx_q, 2'b00} +: 4] == 4'd0) begin
                    board_d[{idx_q, 2'b00} +: 4] = spawn_code;
                    if (spawn2_q) begin
                        spawn2_d = 1'b0;
                        idx_d    = lfsr_q[3:0];
                        scan_d   = '0;
                    end else begin
                        state_d = S_DONE;
                    end
                end else if (scan_q == 4'd15) begin
                    spawn2_d = 1'b0;
                    state_d  = S_DONE;
                end else begin
                    idx_d  = idx_q + 4'd1;
                    scan_d = scan_q + 4'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d == S_DONE && state_q != S_DONE) begin
            moved_d = acc_d;
            over_d  = calc_over(board_d);
        end
    end

    assign board     = board_q;
    assign done      = (state_q == S_DONE);
    assign moved     = moved_q;
    assign game_over = over_q;

endmodule

// File: doc/logic2048_board_ctrl.md
Name: logic2048_board_ctrl

Overview:
- Sequential board controller for the 2048 game datapath; sits directly upstream of the combinational single-line merge unit.
- Holds the 4x4 board of 4-bit log2 tile codes (0 = empty, 1 = tile "2", 11 = tile "2048").
- Accepts move/new-game commands and feeds one line per cycle to the merge unit, oriented for the move direction.
- Writes merged lines back, spawns a pseudo-random tile after any effective move, and flags game over.

Parameters:
- LFSR_SEED, 16'hACE1, reset value of the spawn LFSR (must be nonzero).
- FOUR_PROB_MASK, 3, spawn writes code 2 when (lfsr[7:5] & FOUR_PROB_MASK) == 0, else code 1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  controller idle, command accepted when valid&&ready.
- cmd_new  in  1  1 = new game (cmd_dir ignored), 0 = move.
- cmd_dir  in  2  0 = left, 1 = right, 2 = up, 3 = down.
- ln_x0, ln_x1, ln_x2, ln_x3  out  4 each  line to merge unit; x0 is the end tiles slide toward.
- ln_y0, ln_y1, ln_y2, ln_y3  in  4 each  merged line from merge unit (same cycle, combinational).
- ln_movable  in  1  merge unit reports the line changed.
- board  out  64  cell (r,c) at bits [(r*4+c)*4 +: 4], row 0 top, col 0 left.
- done  out  1  one-cycle pulse at end of every command.
- moved  out  1  last move changed the board; held until next done.
- game_over  out  1  no empty cell and no equal orthogonal neighbours; updated at done.

Behaviour:
- Reset: board=0, cmd_ready=1, done=0, moved=0, game_over=0, ln_x*=0, lfsr=LFSR_SEED, FSM=IDLE.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; advances every non-reset cycle in all states.
- States:
  - IDLE: cmd_ready=1.
  - SHIFT: line counter i = 0..3.
  - SPAWN: scan index, up to 16 cycles.
  - DONE: 1 cycle.
- Move command accepted at cycle T:
  - T+1..T+4 = SHIFT, lines i = 0..3.
  - Each SHIFT cycle drives ln_x* from the board and writes ln_y* back at that clock edge.
  - moved_acc |= ln_movable.
- Line mapping for line i:
  - left: x0..x3 = (i,0),(i,1),(i,2),(i,3).
  - right: (i,3),(i,2),(i,1),(i,0).
  - up: (0,i),(1,i),(2,i),(3,i).
  - down: (3,i),(2,i),(1,i),(0,i).
  - y* is written to the same cells x* came from.
- ln_x* = 0 outside SHIFT.
- After SHIFT:
  - moved_acc=0 → DONE at T+5; board unchanged.
  - Otherwise → SPAWN.
- SPAWN:
  - On entry, idx = lfsr[3:0].
  - Each cycle: if cell idx (= r*4+c) is empty, write the spawn code and go to DONE; else idx = idx+1 mod 16.
  - After 16 cells with none empty, go to DONE with no write (defensive; unreachable after a true move).
- New game command:
  - Board cleared at acceptance edge, moved=0.
  - SPAWN runs twice back-to-back; the second spawn reloads idx from the current lfsr.
  - Then DONE. The merge unit is not used.
- DONE:
  - done=1.
  - moved registered from moved_acc (0 for new game).
  - game_over computed from the final board.
  - Next cycle IDLE, cmd_ready=1.
- cmd_ready=0 in all states except IDLE; cmd_valid is ignored while busy (no queuing).
- Codes pass through from the merge unit unmodified; the controller does no arithmetic on tile values.
- Reset mid-command: abandons the operation immediately; all state returns to reset values, no done pulse.

Test Plan:
- Reset, then left move on empty board → done at T+5, moved=0, board=0, cmd_ready=1 at T+6.
- Board row0 = 1,1,2,0, others empty; left with a behavioural merge model → row0 = 2,2,0,0 written at the T+1 edge, moved=1, exactly one new cell with code 1 or 2 in an empty position, done asserted once.
- Column 2 = rows 0..3 of 1,0,1,2; down → ln_x at T+3 = 2,1,0,1; column becomes rows 0..3 = 0,0,2,2 plus a spawn.
- New game from a non-empty board → board cleared, then exactly two nonzero cells of code 1/2, moved=0, done once, game_over=0.
- Full checkerboard of codes 1/2 → any direction gives moved=0, game_over=1 at done; cmd_valid held high while busy accepts only one command.
- Assert rst during SPAWN → next cycle board=0, cmd_ready=1, done=0; LFSR restarts at 16'hACE1, and the spawn position repeats for an identical command sequence.
